icache_refill: RTL

ICACHE_REFILL -- requirements
Module: icache_refill

---
 rtl/icache_refill_pkg.sv | 34 +++
 rtl/icache_refill_word_reg.sv | 36 +++
 rtl/icache_refill.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/icache_refill_pkg.sv
// ---------------------------------------------------------------------------
// icache_refill_pkg
//   Shared cache constants and types: refill FSM state encoding, bus read
//   type for a whole-line transfer, line geometry and a slot decode helper.
// ---------------------------------------------------------------------------
package icache_refill_pkg;

    localparam int unsigned LINE_WORDS = 4;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned LINE_W     = LINE_WORDS * WORD_W;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned OFFSET_W   = 4;   // byte offset within a 16-byte line

    // Bus read type requesting a whole 16-byte line.
    localparam logic [2:0] RD_TYPE_LINE = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RECV = 2'd2,
        ST_DONE = 2'd3
    } refill_state_e;

    typedef logic [$clog2(LINE_WORDS)-1:0] beat_cnt_t;

    localparam beat_cnt_t LAST_BEAT = beat_cnt_t'(LINE_WORDS - 1);

    // One-hot write enable for the word slot addressed by the beat counter.
    function automatic logic [LINE_WORDS-1:0] slot_onehot(input beat_cnt_t idx);
        slot_onehot      = '0;
        slot_onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/icache_refill_word_reg.sv
// ---------------------------------------------------------------------------
// icache_refill_word_reg
//   One 32-bit word slot of the refill line buffer.
//   Ports:
//     clk  - clock
//     rst  - synchronous active-high reset, clears the word
//     clr  - synchronous clear (start of a new refill)
//     we   - write enable, loads d
//     d    - write data
//     q    - stored word
//   Priority: rst > clr > we.
// ---------------------------------------------------------------------------
module icache_refill_word_reg
    import icache_refill_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              we,
    input  logic [WORD_W-1:0] d,
    output logic [WORD_W-1:0] q
);

    logic [WORD_W-1:0] word_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            word_q <= '0;
        end else if (we) begin
            word_q <= d;
        end
    end

    assign q = word_q;

endmodule

// File: rtl/icache_refill.sv
// ---------------------------------------------------------------------------
// icache_refill
//   Instruction-cache line refill engine. On a miss it issues one bus read
//   for the 16-byte line, assembles the returned 32-bit beats into a 128-bit
//   line and pulses line_valid (with refill_err on a malformed burst).
//   Ports:
//     clk          - clock, all state changes on rising edge
//     rst          - synchronous active-high reset (highest priority)
//     refill_req   - miss request, only sampled in IDLE
//     refill_addr  - miss address, bits [3:0] ignored
//     busy         - high whenever not IDLE
//     rd_req       - bus read request (registered)
//     rd_type      - bus read type, constant whole-line
//     rd_addr      - line-aligned read address
//     rd_rdy       - bus accepts the request
//     ret_valid    - return beat valid
//     ret_last     - final return beat
//     ret_data     - return beat data
//     line_data    - assembled line, word n in bits [32n+31:32n]
//     line_valid   - one-cycle pulse, line_data complete
//     refill_err   - one-cycle pulse with line_valid on wrong beat count
// ---------------------------------------------------------------------------
module icache_refill
    import icache_refill_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              refill_req,
    input  logic [ADDR_W-1:0] refill_addr,
    output logic              busy,
    output logic              rd_req,
    output logic [2:0]        rd_type,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_rdy,
    input  logic              ret_valid,
    input  logic              ret_last,
    input  logic [WORD_W-1:0] ret_data,
    output logic [LINE_W-1:0] line_data,
    output logic              line_valid,
    output logic              refill_err
);

    refill_state_e              state_q, state_d;
    beat_cnt_t                  beat_cnt_q, beat_cnt_d;
    logic [ADDR_W-OFFSET_W-1:0] line_addr_q, line_addr_d;
    logic                       err_q, err_d;

    logic                       busy_q;
    logic                       rd_req_q;
    logic                       line_valid_q;
    logic                       refill_err_q;

    logic                       clr_line;
    logic [LINE_WORDS-1:0]      slot_we;

    // Byte offset within the line is irrelevant to a whole-line read.
    logic                       unused_offset_bits;
    assign unused_offset_bits = ^refill_addr[OFFSET_W-1:0];

    // -----------------------------------------------------------------------
    // Next-state / datapath control
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        line_addr_d = line_addr_q;
        err_d       = err_q;
        clr_line    = 1'b0;
        slot_we     = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (refill_req) begin
                    state_d     = ST_REQ;
                    line_addr_d = refill_addr[ADDR_W-1:OFFSET_W];
                    beat_cnt_d  = '0;
                    err_d       = 1'b0;
                    clr_line    = 1'b1;
                end
            end

            ST_REQ: begin
                // rd_req is high throughout REQ, so rd_rdy alone completes
                // the handshake.
                if (rd_rdy) begin
                    state_d = ST_RECV;
                end
            end

            ST_RECV: begin
                if (ret_valid) begin
                    slot_we    = slot_onehot(beat_cnt_q);
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (ret_last) begin
                        state_d = ST_DONE;
                        // Short burst: last beat arrived before the final slot.
                        if (beat_cnt_q != LAST_BEAT) begin
                            err_d = 1'b1;
                        end
                    end else if (beat_cnt_q == LAST_BEAT) begin
                        // Overlong burst: counter wraps and slot 0 is
                        // overwritten; remember it until DONE.
                        err_d = 1'b1;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State and registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            beat_cnt_q   <= '0;
            line_addr_q  <= '0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
            rd_req_q     <= 1'b0;
            line_valid_q <= 1'b0;
            refill_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            line_addr_q  <= line_addr_d;
            err_q        <= err_d;
            // Outputs are decoded from the next state so they are registered
            // yet line up with the state they describe.
            busy_q       <= (state_d != ST_IDLE);
            rd_req_q     <= (state_d == ST_REQ);
            line_valid_q <= (state_d == ST_DONE);
            refill_err_q <= (state_d == ST_DONE) && err_d;
        end
    end

    // -----------------------------------------------------------------------
    // Line buffer: one write-enabled register per word slot
    // -----------------------------------------------------------------------
    for (genvar i = 0; i < LINE_WORDS; i++) begin : g_slot
        logic [WORD_W-1:0] word;

        icache_refill_word_reg u_word (
            .clk (clk),
            .rst (rst),
            .clr (clr_line),
            .we  (slot_we[i]),
            .d   (ret_data),
            .q   (word)
        );

        assign line_data[i*WORD_W +: WORD_W] = word;
    end

    assign busy       = busy_q;
    assign rd_req     = rd_req_q;
    assign rd_type    = RD_TYPE_LINE;
    assign rd_addr    = {line_addr_q, {OFFSET_W{1'b0}}};
    assign line_valid = line_valid_q;
    assign refill_err = refill_err_q;

endmodule
